// File: rtl/fb_write_arbiter_pkg.sv
// Shared video definitions: framebuffer geometry defaults and arbiter state encoding.
// Used by the framebuffer write arbiter and the framebuffer/VGA blocks.
package fb_write_arbiter_pkg;

    localparam int          FB_ADDR_WIDTH     = 15;
    localparam int unsigned FB_PIXELS_DEFAULT = 19200;  // QQVGA 160x120

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned pixels);
        return addr < pixels;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Two-requester pixel write port: each requester offers valid/addr/pixel and receives ready.
interface fb_write_arbiter_if
    import fb_write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_pixel;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_pixel;
    logic                  req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_pixel,
        output req1_valid, req1_addr, req1_pixel,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_pixel,
        input  req1_valid, req1_addr, req1_pixel,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/fb_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins outright, a tie goes to the side ptr favours.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin between two pixel writers, with a full-screen
// clear sweep that locks both writers out until the last address has been written.
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int unsigned FB_PIXELS  = FB_PIXELS_DEFAULT
) (
    input  logic                  clk_25,
    input  logic                  reset_n,
    input  logic                  clear_start,
    input  logic                  clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    fb_write_arbiter_if.slave     req,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  pixel,
    output logic                  drop_err
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - 1);

    arb_state_e            state;
    logic                  ptr;       // 0: favour req0 on a tie
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clr_val;

    logic [1:0]            valids;
    logic [1:0]            grant;
    logic                  serve;
    logic                  accept0;
    logic                  accept1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_pixel;
    logic                  sel_in_range;

    assign valids = {req.req1_valid, req.req0_valid};

    rr_arbiter2 u_rr (
        .valid (valids),
        .ptr   (ptr),
        .grant (grant)
    );

    // Gating with reset_n keeps both readys low for as long as reset is held.
    assign serve          = reset_n && (state == ST_IDLE) && !clear_start;
    assign req.req0_ready = serve && grant[0];
    assign req.req1_ready = serve && grant[1];
    assign accept0        = req.req0_ready && req.req0_valid;
    assign accept1        = req.req1_ready && req.req1_valid;

    always_comb begin
        sel_addr  = req.req0_addr;
        sel_pixel = req.req0_pixel;
        if (accept1) begin
            sel_addr  = req.req1_addr;
            sel_pixel = req.req1_pixel;
        end
        sel_in_range = addr_in_range(32'(sel_addr), FB_PIXELS);
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            clr_cnt    <= '0;
            clr_val    <= 1'b0;
            we         <= 1'b0;
            write_addr <= '0;
            pixel      <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            we         <= 1'b0;
            clear_done <= 1'b0;
            drop_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state      <= ST_CLEAR;
                        clr_val    <= clear_value;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end else if (accept0 || accept1) begin
                        ptr <= accept0;
                        if (sel_in_range) begin
                            we         <= 1'b1;
                            write_addr <= sel_addr;
                            pixel      <= sel_pixel;
                        end else begin
                            drop_err <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    we         <= 1'b1;
                    write_addr <= clr_cnt;
                    pixel      <= clr_val;
                    // Leaving on the last address lets writers be served while it is on the bus.
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= ST_IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter: table-driven IDLE vectors plus hand-written clear/reset
// sequences, with registered outputs checked one cycle later through an expectation queue.
module tb_fb_write_arbiter;
    localparam int AW = 15;
    localparam int NPIX = 19200;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic          p0;
        logic          v1;
        logic [AW-1:0] a1;
        logic          p1;
        logic          cs;
        logic          cv;
        logic          er0;
        logic          er1;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          pix;
        logic          drop;
        logic          done;
        logic          busy;
    } exp_t;

    localparam int K_NORM = 0;
    localparam int K_CS   = 1;
    localparam int K_CLR  = 2;

    logic          clk_25 = 1'b0;
    logic          reset_n;
    logic          clear_start;
    logic          clear_value;
    logic          clear_busy;
    logic          clear_done;
    logic          we;
    logic [AW-1:0] write_addr;
    logic          pixel;
    logic          drop_err;

    fb_write_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    fb_write_arbiter #(.ADDR_WIDTH(AW), .FB_PIXELS(NPIX)) dut (
        .clk_25      (clk_25),
        .reset_n     (reset_n),
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .req         (bus),
        .we          (we),
        .write_addr  (write_addr),
        .pixel       (pixel),
        .drop_err    (drop_err)
    );

    always #20 clk_25 = ~clk_25;

    int            n_cmp = 0;
    int            n_fail = 0;
    exp_t          q[$];
    logic [AW-1:0] last_addr;
    logic          last_pix;
    logic          clr_val;
    vec_t          tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        chk("we", 32'(we), 32'(e.we));
        chk("write_addr", 32'(write_addr), 32'(e.addr));
        chk("pixel", 32'(pixel), 32'(e.pix));
        chk("drop_err", 32'(drop_err), 32'(e.drop));
        chk("clear_done", 32'(clear_done), 32'(e.done));
        chk("clear_busy", 32'(clear_busy), 32'(e.busy));
    endtask

    task automatic step(input vec_t v, input int kind, input int k);
        exp_t e;
        @(negedge clk_25);
        check_out();
        bus.req0_valid = v.v0;
        bus.req0_addr  = v.a0;
        bus.req0_pixel = v.p0;
        bus.req1_valid = v.v1;
        bus.req1_addr  = v.a1;
        bus.req1_pixel = v.p1;
        clear_start    = v.cs;
        clear_value    = v.cv;
        #1;
        chk("req0_ready", 32'(bus.req0_ready), 32'(v.er0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(v.er1));
        e = '{we: 1'b0, addr: last_addr, pix: last_pix, drop: 1'b0, done: 1'b0, busy: 1'b0};
        if (kind == K_CS) begin
            e.busy = 1'b1;
        end else if (kind == K_CLR) begin
            e.we   = 1'b1;
            e.addr = AW'(k);
            e.pix  = clr_val;
            e.done = (k == NPIX - 1);
            e.busy = (k != NPIX - 1);
        end else if ((v.er0 && v.v0) || (v.er1 && v.v1)) begin
            logic [AW-1:0] a;
            logic          p;
            a = (v.er0 && v.v0) ? v.a0 : v.a1;
            p = (v.er0 && v.v0) ? v.p0 : v.p1;
            if (int'(a) < NPIX) begin
                e.we = 1'b1;
                e.addr = a;
                e.pix = p;
            end else begin
                e.drop = 1'b1;
            end
        end
        if (e.we) begin
            last_addr = e.addr;
            last_pix  = e.pix;
        end
        q.push_back(e);
    endtask

    // Sweep cycles with both writers asserting; clear_value is driven opposite to the latched value.
    task automatic run_clear(input int restart_at, input int reset_at);
        vec_t v;
        for (int k = 0; k < NPIX; k++) begin
            v = '{1'b1, AW'(k), 1'b1, 1'b1, AW'(k + 3), 1'b0,
                  (k == restart_at), ~clr_val, 1'b0, 1'b0};
            step(v, K_CLR, k);
            if (k == reset_at) return;
        end
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset_n        = 1'b0;
        clear_start    = 1'b0;
        clear_value    = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = AW'(9);
        bus.req0_pixel = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = AW'(8);
        bus.req1_pixel = 1'b1;
        last_addr      = '0;
        last_pix       = 1'b0;
        clr_val        = 1'b0;
        #1;
        chk("rst_we", 32'(we), 0);
        chk("rst_write_addr", 32'(write_addr), 0);
        chk("rst_pixel", 32'(pixel), 0);
        chk("rst_clear_busy", 32'(clear_busy), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_drop_err", 32'(drop_err), 0);
        chk("rst_req0_ready", 32'(bus.req0_ready), 0);
        chk("rst_req1_ready", 32'(bus.req1_ready), 0);
        repeat (3) @(posedge clk_25);
        @(negedge clk_25);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset_n        = 1'b1;

        //          v0  a0          p0  v1  a1          p1  cs  cv  er0 er1
        tbl[0]  = '{1, AW'(100),   1, 0, AW'(0),     0, 0, 0, 1, 0};
        tbl[1]  = '{0, AW'(0),     0, 0, AW'(0),     0, 0, 0, 0, 0};
        tbl[2]  = '{1, AW'(10),    0, 1, AW'(20),    1, 0, 0, 0, 1};
        tbl[3]  = '{1, AW'(11),    1, 1, AW'(21),    0, 0, 0, 1, 0};
        tbl[4]  = '{1, AW'(12),    0, 1, AW'(22),    1, 0, 0, 0, 1};
        tbl[5]  = '{1, AW'(13),    1, 1, AW'(23),    1, 0, 0, 1, 0};
        tbl[6]  = '{0, AW'(0),     0, 1, AW'(19200), 1, 0, 0, 0, 1};
        tbl[7]  = '{1, AW'(19199), 0, 0, AW'(0),     0, 0, 0, 1, 0};
        tbl[8]  = '{0, AW'(0),     0, 1, AW'(0),     1, 0, 0, 0, 1};
        tbl[9]  = '{1, AW'(32767), 1, 0, AW'(0),     0, 0, 0, 1, 0};
        tbl[10] = '{0, AW'(0),     0, 0, AW'(0),     0, 0, 0, 0, 0};
        tbl[11] = '{1, AW'(40),    1, 0, AW'(0),     0, 0, 0, 1, 0};
        tbl[12] = '{1, AW'(41),    0, 1, AW'(42),    1, 1, 1, 0, 0};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].cs) clr_val = tbl[i].cv;
            step(tbl[i], tbl[i].cs ? K_CS : K_NORM, 0);
        end

        // Full sweep with both writers waiting; req1 is served in the clear_done cycle.
        run_clear(-1, -1);
        step('{1, AW'(50), 0, 1, AW'(60), 1, 0, 0, 0, 1}, K_NORM, 0);

        // Second clear, with clear_start pulsed again mid-sweep.
        clr_val = 1'b0;
        step('{1, AW'(3), 1, 0, AW'(0), 0, 1, 0, 0, 0}, K_CS, 0);
        run_clear(7000, -1);
        step('{1, AW'(77), 1, 0, AW'(0), 0, 0, 0, 1, 0}, K_NORM, 0);
        step('{0, AW'(0), 0, 0, AW'(0), 0, 0, 0, 0, 0}, K_NORM, 0);
        step('{0, AW'(0), 0, 0, AW'(0), 0, 0, 0, 0, 0}, K_NORM, 0);

        // Third clear, aborted by reset while address 5000 is on the bus.
        clr_val = 1'b1;
        step('{0, AW'(0), 0, 0, AW'(0), 0, 1, 1, 0, 0}, K_CS, 0);
        run_clear(-1, 5000);
        @(negedge clk_25);
        check_out();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        clear_start    = 1'b0;
        #5;
        reset_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 0);
        chk("arst_write_addr", 32'(write_addr), 0);
        chk("arst_pixel", 32'(pixel), 0);
        chk("arst_clear_busy", 32'(clear_busy), 0);
        chk("arst_clear_done", 32'(clear_done), 0);
        chk("arst_drop_err", 32'(drop_err), 0);
        chk("arst_req0_ready", 32'(bus.req0_ready), 0);
        chk("arst_req1_ready", 32'(bus.req1_ready), 0);
        q.delete();
        last_addr = '0;
        last_pix  = 1'b0;
        repeat (2) @(posedge clk_25);
        @(negedge clk_25);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_clear_busy", 32'(clear_busy), 0);
        chk("post_rst_we", 32'(we), 0);

        // Pointer restarts favouring req0, then alternates.
        step('{1, AW'(200), 1, 1, AW'(300), 0, 0, 0, 1, 0}, K_NORM, 0);
        step('{1, AW'(201), 0, 1, AW'(301), 1, 0, 0, 0, 1}, K_NORM, 0);
        step('{0, AW'(0), 0, 0, AW'(0), 0, 0, 0, 0, 0}, K_NORM, 0);
        @(negedge clk_25);
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, framebuffer write-address width (QQVGA 160x120).
REQ-002 Parameter FB_PIXELS, default 19200, number of valid framebuffer locations; legal addresses are 0..FB_PIXELS-1.
REQ-003 clk_25  input  1  pixel-domain clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 clear_start  input  1  single-cycle request to fill the whole framebuffer with clear_value.
REQ-006 clear_value  input  1  fill pixel; sampled only in the cycle clear_start is accepted.
REQ-007 clear_busy  output  1  high while a clear sweep is in progress.
REQ-008 clear_done  output  1  one-cycle pulse after the last clear write is issued.
REQ-009 req0_valid / req1_valid  input  1 each  requester N has a pixel write pending.
REQ-010 req0_addr / req1_addr  input  ADDR_WIDTH each  target address of requester N.
REQ-011 req0_pixel / req1_pixel  input  1 each  pixel value of requester N.
REQ-012 req0_ready / req1_ready  output  1 each  requester N's write is accepted this cycle.
REQ-013 we  output  1  framebuffer write enable.
REQ-014 write_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-015 pixel  output  1  framebuffer write data.
REQ-016 drop_err  output  1  one-cycle pulse when an accepted request carried an out-of-range address.

Function
REQ-017 States: IDLE (serving requesters) and CLEAR (sweeping); no other states.
REQ-018 Handshake: a write is accepted when reqN_valid && reqN_ready; reqN_ready is combinational from state, valids and the round-robin pointer.
REQ-019 In IDLE with clear_start low: one valid requester gets ready; when both are valid, the requester not granted last gets ready; at most one ready per cycle.
REQ-020 The round-robin pointer updates only on acceptance; after reset it favours req0.
REQ-021 we, write_addr and pixel are registered: an accepted in-range request appears on them exactly one cycle after acceptance with we=1 for one cycle.
REQ-022 An accepted request with address >= FB_PIXELS produces we=0 and drop_err=1 in the following cycle; the pointer still advances.
REQ-023 With no acceptance and no clear write, we=0 the following cycle; write_addr and pixel hold their last values.
REQ-024 clear_start high in IDLE: both readys are 0 that cycle, even if valids are high; the state becomes CLEAR next cycle, with clear_value latched.
REQ-025 In CLEAR, one write per cycle to addresses 0,1,...,FB_PIXELS-1 with pixel=latched clear_value; both readys are 0; clear_busy=1.
REQ-026 The first clear write (addr 0) appears on the outputs the cycle after CLEAR is entered; the last write is at FB_PIXELS-1.
REQ-027 clear_done pulses in the same cycle as the addr FB_PIXELS-1 write; the state returns to IDLE that cycle, so requesters can be accepted in that cycle.
REQ-028 clear_start during CLEAR is ignored; it neither restarts nor extends the sweep.
REQ-029 The clear counter is ADDR_WIDTH bits wide and never wraps past FB_PIXELS-1.

Reset
REQ-030 Asserting reset_n low at any time, including mid-sweep, aborts immediately and forces: state=IDLE, we=0, write_addr=0, pixel=0, clear_busy=0, clear_done=0, drop_err=0, readys=0, pointer favouring req0.
REQ-031 After deassertion, operation starts in IDLE with no pending clear.

Structure
REQ-032 FB_PIXELS, ADDR_WIDTH defaults and the state encoding live in the shared video package used by the framebuffer and VGA blocks.
REQ-033 Round-robin grant logic is one sub-module, rr_arbiter2: inputs valids and pointer, outputs one-hot grant; everything else stays flat.

Verification
REQ-034 Only req0 valid, addr 100, pixel 1 -> req0_ready=1 same cycle; next cycle we=1, write_addr=100, pixel=1.
REQ-035 Both valid continuously after reset -> grants alternate req0,req1,req0,...; one we per cycle with matching addr/pixel.
REQ-036 req1 valid, addr 19200 -> req1_ready=1; next cycle we=0, drop_err=1.
REQ-037 clear_start with clear_value=1 while both requesters are valid -> readys 0 for 19201 cycles; we=1 at addr 0..19199, pixel=1; clear_done at addr 19199; requester accepted that same cycle.
REQ-038 reset_n low at clear addr 5000 -> all outputs 0 asynchronously; after release, clear_busy=0 and req0 accepted normally.
REQ-039 clear_start pulsed again mid-sweep -> sweep length stays 19200 writes; a single clear_done.
